// File: rtl/team_08_pkg.sv
// rtl/team_08_pkg.sv - shared game state type and score constants
package team_08_pkg;

    localparam int SCORE_W           = 7;
    localparam int SCORE_SAT_DEFAULT = 127;

    // Three bits wide so unused codes exist and can be mapped safely to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        WIN  = 3'd2,
        OVER = 3'd3
    } state_t;

    function automatic state_t sanitize_state(input state_t s);
        case (s)
            RUN, WIN, OVER: return s;
            default:        return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/team_08_score_tracker_bin2bcd.sv
// rtl/team_08_score_tracker_bin2bcd.sv - combinational 7-bit to 3-digit BCD (double dabble)
module team_08_bin2bcd
    import team_08_pkg::*;
(
    input  logic [SCORE_W-1:0] bin,
    output logic [3:0]         hundreds,
    output logic [3:0]         tens,
    output logic [3:0]         ones
);

    // Layout: [18:15] hundreds, [14:11] tens, [10:7] ones, [6:0] binary input.
    logic [18:0] sh;

    always_comb begin
        sh = {12'd0, bin};
        for (int i = 0; i < SCORE_W; i++) begin
            if (sh[10:7] >= 4'd5)  sh[10:7]  = sh[10:7]  + 4'd3;
            if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
            if (sh[18:15] >= 4'd5) sh[18:15] = sh[18:15] + 4'd3;
            sh = sh << 1;
        end
        hundreds = sh[18:15];
        tens     = sh[14:11];
        ones     = sh[10:7];
    end

endmodule

// File: rtl/team_08_score_tracker.sv
// rtl/team_08_score_tracker.sv - time-based run score, session high score and BCD display digits
module team_08_score_tracker
    import team_08_pkg::*;
#(
    parameter int TICK_DIV  = 1_000_000,
    parameter int SCORE_SAT = SCORE_SAT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  state_t             state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record,
    output logic               tick,
    output logic [3:0]         bcd_hundreds,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_ones
);

    localparam int                 DIV_W    = 24;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] SAT      = SCORE_W'(SCORE_SAT);

    logic [DIV_W-1:0] div_cnt;
    state_t           prev_state;
    state_t           cur_state;
    logic [3:0]       hundreds_c;
    logic [3:0]       tens_c;
    logic [3:0]       ones_c;

    assign cur_state = sanitize_state(state);

    team_08_bin2bcd u_bin2bcd (
        .bin      (score),
        .hundreds (hundreds_c),
        .tens     (tens_c),
        .ones     (ones_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score        <= '0;
            high_score   <= '0;
            new_record   <= 1'b0;
            tick         <= 1'b0;
            div_cnt      <= '0;
            prev_state   <= IDLE;
            bcd_hundreds <= 4'd0;
            bcd_tens     <= 4'd0;
            bcd_ones     <= 4'd0;
        end else begin
            prev_state   <= cur_state;
            bcd_hundreds <= hundreds_c;
            bcd_tens     <= tens_c;
            bcd_ones     <= ones_c;

            case (cur_state)
                RUN: begin
                    if (prev_state != RUN) new_record <= 1'b0;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        tick    <= 1'b1;
                        // Tick keeps pulsing at saturation; game speed still follows time.
                        if (score < SAT) score <= score + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        tick    <= 1'b0;
                    end
                end
                WIN, OVER: begin
                    tick <= 1'b0;
                    if (prev_state == RUN && score > high_score) begin
                        high_score <= score;
                        new_record <= 1'b1;
                    end
                end
                default: begin
                    score   <= '0;
                    div_cnt <= '0;
                    tick    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_team_08_score_tracker.sv
// tb/tb_team_08_score_tracker.sv - self-checking bench for team_08_score_tracker
module tb_team_08_score_tracker;
    import team_08_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst4, rst1;
    state_t st4, st1;
    logic [6:0] score4, high4, score1, high1;
    logic       nr4, tick4, nr1, tick1;
    logic [3:0] h4, t4, o4, h1, t1, o1;

    team_08_score_tracker #(.TICK_DIV(4)) u4 (
        .clk(clk), .reset(rst4), .state(st4), .score(score4), .high_score(high4),
        .new_record(nr4), .tick(tick4), .bcd_hundreds(h4), .bcd_tens(t4), .bcd_ones(o4)
    );

    team_08_score_tracker #(.TICK_DIV(1)) u1 (
        .clk(clk), .reset(rst1), .state(st1), .score(score1), .high_score(high1),
        .new_record(nr1), .tick(tick1), .bcd_hundreds(h1), .bcd_tens(t1), .bcd_ones(o1)
    );

    typedef struct {
        int score;
        int tick;
        int high;
        int nr;
    } exp_t;

    typedef struct {
        logic [2:0] code;
        int         score;
        int         tick;
        int         high;
        int         nr;
    } vec_t;

    exp_t q4[$];
    exp_t q1[$];
    vec_t vecs[11];

    int checks   = 0;
    int failures = 0;
    int run_k     = 0;
    int exp_score = 0;
    int exp_high  = 0;
    int exp_nr    = 0;
    bit was_run   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc4(input state_t s, input exp_t e);
        exp_t p;
        q4.push_back(e);
        st4 = s;
        @(posedge clk);
        #1;
        p = q4.pop_front();
        chk("u4 score", int'(score4), p.score);
        chk("u4 tick", int'(tick4), p.tick);
        chk("u4 high_score", int'(high4), p.high);
        chk("u4 new_record", int'(nr4), p.nr);
    endtask

    task automatic run4(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            run_k++;
            exp_score = (run_k / 4 > 127) ? 127 : run_k / 4;
            exp_nr    = 0;
            was_run   = 1;
            e.score = exp_score;
            e.tick  = (run_k % 4 == 0) ? 1 : 0;
            e.high  = exp_high;
            e.nr    = exp_nr;
            cyc4(RUN, e);
        end
    endtask

    task automatic hold4(input state_t s, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (s != IDLE && was_run && exp_score > exp_high) begin
                exp_high = exp_score;
                exp_nr   = 1;
            end
            if (s == IDLE) begin
                exp_score = 0;
                run_k     = 0;
            end
            was_run = 0;
            e.score = exp_score;
            e.tick  = 0;
            e.high  = exp_high;
            e.nr    = exp_nr;
            cyc4(s, e);
        end
    endtask

    task automatic chk_bcd4(input string nm, input int exp);
        chk(nm, int'({h4, t4, o4}), exp);
    endtask

    initial begin
        // TICK_DIV=1 instance: {state code, score, tick, high_score, new_record}
        vecs[0]  = '{3'd0, 0, 0, 0, 0};
        vecs[1]  = '{3'd1, 1, 1, 0, 0};
        vecs[2]  = '{3'd1, 2, 1, 0, 0};
        vecs[3]  = '{3'd1, 3, 1, 0, 0};
        vecs[4]  = '{3'd1, 4, 1, 0, 0};
        vecs[5]  = '{3'd1, 5, 1, 0, 0};
        vecs[6]  = '{3'd5, 0, 0, 0, 0};
        vecs[7]  = '{3'd1, 1, 1, 0, 0};
        vecs[8]  = '{3'd1, 2, 1, 0, 0};
        vecs[9]  = '{3'd3, 2, 0, 2, 1};
        vecs[10] = '{3'd0, 0, 0, 2, 1};

        rst4 = 1'b1;
        rst1 = 1'b1;
        st4  = IDLE;
        st1  = IDLE;
        repeat (2) @(posedge clk);
        #1;
        chk("reset score", int'(score4), 0);
        chk("reset high_score", int'(high4), 0);
        chk("reset new_record", int'(nr4), 0);
        chk("reset tick", int'(tick4), 0);
        chk_bcd4("reset bcd", 12'h000);
        chk("reset u1 score", int'(score1), 0);
        rst4 = 1'b0;
        rst1 = 1'b0;

        // First game: ticks every 4 RUN cycles, then stop mid-period at 25.
        hold4(IDLE, 2);
        run4(40);
        chk("score after 40", int'(score4), 10);
        run4(1);
        chk_bcd4("bcd of 10", 12'h010);
        run4(61);
        chk("score before over", int'(score4), 25);
        hold4(OVER, 4);
        chk("high after game1", int'(high4), 25);
        chk("record after game1", int'(nr4), 1);
        chk_bcd4("bcd of 25", 12'h025);
        hold4(IDLE, 2);
        chk("idle score", int'(score4), 0);
        chk("idle keeps record", int'(nr4), 1);

        // Lower then equal final score: high score holds, no record.
        run4(48);
        hold4(WIN, 2);
        chk("high after game2", int'(high4), 25);
        hold4(IDLE, 1);
        run4(100);
        hold4(OVER, 2);
        chk("record on equal", int'(nr4), 0);
        hold4(IDLE, 1);

        // Saturation with continued ticking.
        run4(600);
        run4(1);
        chk("saturated score", int'(score4), 127);
        chk_bcd4("bcd of 127", 12'h127);
        hold4(OVER, 2);
        hold4(IDLE, 1);

        // Asynchronous reset in the middle of a run.
        run4(240);
        chk("score before reset", int'(score4), 60);
        rst4 = 1'b1;
        #1;
        chk("async score", int'(score4), 0);
        chk("async high_score", int'(high4), 0);
        chk("async new_record", int'(nr4), 0);
        chk("async tick", int'(tick4), 0);
        chk_bcd4("async bcd", 12'h000);
        @(posedge clk);
        #1;
        st4  = IDLE;
        rst4 = 1'b0;
        exp_score = 0;
        exp_high  = 0;
        exp_nr    = 0;
        run_k     = 0;
        was_run   = 0;
        hold4(IDLE, 1);

        // TICK_DIV=1 table, including an illegal state encoding.
        foreach (vecs[i]) begin
            exp_t e;
            exp_t p;
            e.score = vecs[i].score;
            e.tick  = vecs[i].tick;
            e.high  = vecs[i].high;
            e.nr    = vecs[i].nr;
            q1.push_back(e);
            st1 = state_t'(vecs[i].code);
            @(posedge clk);
            #1;
            p = q1.pop_front();
            chk($sformatf("u1 score v%0d", i), int'(score1), p.score);
            chk($sformatf("u1 tick v%0d", i), int'(tick1), p.tick);
            chk($sformatf("u1 high v%0d", i), int'(high1), p.high);
            chk($sformatf("u1 record v%0d", i), int'(nr1), p.nr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/team_08_score_tracker.md
Name: team_08_score_tracker

Overview:
Produces the run score consumed by team_08_GameState and the BCD digits shown on the seven-segment display. It consumes the registered game state and is the other half of the score/state loop. While the game is in RUN it counts time-based points. It freezes the score in WIN or OVER, keeps a session high score across games, and clears the live score in IDLE.

Parameters:
TICK_DIV, 1_000_000, clk cycles per scored point; legal range 1 to 2^24.
SCORE_SAT, 127, saturation value of the score; must be no greater than 2^7-1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
state  input  state_t  registered game state from team_08_GameState
score  output  7  live score, binary; feeds GameState.score
high_score  output  7  best final score since reset
new_record  output  1  the last finished game set a new high score
tick  output  1  one-cycle pulse on each point increment
bcd_hundreds  output  4  BCD hundreds digit of score
bcd_tens  output  4  BCD tens digit of score
bcd_ones  output  4  BCD ones digit of score

Behaviour:
- Reset (async, while reset=1):
  - score, high_score, new_record, tick, all BCD digits = 0.
  - Prescaler div_cnt = 0; prev_state = IDLE.
  - Reset asserted mid-run clears everything immediately, including high_score.
- Invalid state encodings are treated as IDLE.
- IDLE:
  - score <= 0, div_cnt <= 0, tick <= 0.
  - high_score and new_record hold.
- RUN:
  - div_cnt counts 0..TICK_DIV-1.
  - On the edge where div_cnt == TICK_DIV-1 and state == RUN:
    - div_cnt <= 0.
    - score <= min(score+1, SCORE_SAT).
    - tick <= 1 for exactly one cycle, coincident with the new score value.
  - Otherwise div_cnt increments and tick <= 0.
  - The first tick occurs TICK_DIV cycles after the first RUN cycle.
  - TICK_DIV=1 gives a tick every RUN cycle.
- Saturation: at SCORE_SAT the score holds, but tick keeps pulsing at the normal rate. Elapsed time still drives game speed.
- Entering RUN (prev_state != RUN, state == RUN): new_record <= 0. score is already 0 from IDLE.
- WIN / OVER:
  - score and div_cnt freeze; tick = 0.
  - No partial point is awarded for an unfinished divider period.
- End of game (prev_state == RUN, state is WIN or OVER), evaluated on that first non-RUN edge using the frozen score:
  - If score > high_score: high_score <= score and new_record <= 1.
  - Equal or lower score: no change, and new_record stays 0.
- Simultaneous events: updates use state sampled at the edge. If state is RUN on a wrap edge, the increment happens even if state leaves RUN on the next cycle.
- BCD outputs:
  - Registered; they reflect score with 1-cycle latency.
  - Range 000-127. Digits are always valid BCD (0-9).
- prev_state is a plain register of state, used only for edge detection.

Decomposition:
- team_08_pkg holds:
  - state_t (IDLE, RUN, WIN, OVER), shared with team_08_GameState.
  - SCORE_W = 7.
  - The default SCORE_SAT.
- Sub-module team_08_bin2bcd: combinational 7-bit to 3-digit double-dabble converter. Its outputs are registered in the parent.
- The top level holds the prescaler, score/high-score registers and edge detection. Target is about 150-200 lines total.

Test Plan:
1. TICK_DIV=4, reset, then IDLE→RUN held 40 cycles -> ticks on RUN cycles 4, 8, …, 40; score = 10; next cycle BCD = 0/1/0.
2. RUN until score = 25, then OVER with div_cnt = 2 -> score stays 25 and no further tick; high_score = 25 and new_record = 1 one edge later. Then IDLE -> score = 0, high_score = 25, new_record = 1.
3. Second game: RUN clears new_record to 0; end in WIN at score = 12 -> high_score stays 25, new_record = 0. Then a third game ending at exactly 25 -> high_score 25, new_record 0.
4. RUN for 600 cycles with TICK_DIV=4 -> score saturates at 127, tick still pulses every 4 cycles, BCD = 1/2/7.
5. Assert reset for 1 cycle at score = 60 during RUN -> all outputs 0 asynchronously, before the next clk edge; high_score 0.
6. TICK_DIV=1, RUN for 5 cycles -> tick high every cycle, score = 5. Drive state with an illegal encoding -> behaves as IDLE: score 0, tick 0.
